// File: rtl/ibr128_pkg.sv
// -----------------------------------------------------------------------------
// ibr128_pkg
// Shared types for the IBR128 block sequencer: FSM state encoding, the
// mode-of-operation encoding understood by the cipher core, the 128-bit block
// type and a helper that selects the next chaining value.
// -----------------------------------------------------------------------------
package ibr128_pkg;

    // One cipher block.
    typedef logic [127:0] blk128_t;

    // Sequencer states. IDLE must stay at zero so a cleared register means IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } seq_state_e;

    // Mode of operation. Codes 2'b10 and 2'b11 are reserved and behave as ECB.
    typedef enum logic [1:0] {
        SOM_ECB = 2'b00,
        SOM_CBC = 2'b01
    } som_e;

    // True only for CBC; every other code (including reserved ones) is ECB.
    function automatic logic som_is_cbc(input logic [1:0] som);
        return (som == SOM_CBC);
    endfunction

    // Chaining value to use for the next block once the current one is
    // accepted downstream. In CBC encrypt the result chains forward; in CBC
    // decrypt the consumed ciphertext chains forward; ECB keeps the old value.
    function automatic blk128_t chain_next(
        input logic [1:0] som,
        input logic       encrypt,
        input blk128_t    result,
        input blk128_t    consumed,
        input blk128_t    current
    );
        blk128_t nxt;
        if (!som_is_cbc(som)) begin
            nxt = current;
        end else if (encrypt) begin
            nxt = result;
        end else begin
            nxt = consumed;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ibr128_block_seq.sv
// -----------------------------------------------------------------------------
// ibr128_block_seq
// Sequencer in front of the IBR128 cipher core. Takes 128-bit blocks from a
// valid/ready input stream, presents each block plus the current chaining
// value to the core, pulses the core enable, waits for cipherReady and hands
// the result out on a valid/ready output stream. The chaining register is
// maintained here so software programs the IV once per session.
//
// Optional build macro:
//   IBR128_SEQ_TIMEOUT_EN  - adds a watchdog over RUN/DRAIN. After
//                            TIMEOUT_CYCLES waiting cycles the block is
//                            dropped, err is set and the FSM returns to IDLE.
//                            Without it the sequencer waits forever and err=0.
//
// Parameters:
//   TIMEOUT_CYCLES - watchdog limit in cycles (watchdog build only, >= 1)
//   CNT_W          - width of the saturating session block counter
//
// Ports:
//   Clk, Rst                     clock, synchronous active-high reset
//   cfg_start                    pulse in IDLE: latch cfg_*, clear counter,
//                                load chain register from cfg_iv, clear err
//   cfg_encrypt, cfg_som, cfg_iv session configuration
//   in_valid/in_ready/in_data    input block stream
//   out_valid/out_ready/out_data result stream
//   core_*                       cipher core interface
//   blk_count                    blocks completed since cfg_start (saturating)
//   busy                         FSM not in IDLE
//   err                          sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module ibr128_block_seq
    import ibr128_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cfg_start,
    input  logic             cfg_encrypt,
    input  logic [1:0]       cfg_som,
    input  logic [127:0]     cfg_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             core_enable,
    output logic             core_encrypt,
    output logic [1:0]       core_som,
    output logic [127:0]     core_text,
    output logic [127:0]     core_iv,
    input  logic [127:0]     core_text_out,
    input  logic             core_ready,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy,
    output logic             err
);

    // Reject nonsensical parameterisations at elaboration time.
    if ((TIMEOUT_CYCLES < 1) || (CNT_W < 1)) begin : g_param_check
        $error("ibr128_block_seq: TIMEOUT_CYCLES and CNT_W must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_e       state_q, state_d;
    blk128_t          text_q, text_d;
    blk128_t          result_q, result_d;
    blk128_t          chain_q, chain_d;
    logic             encrypt_q, encrypt_d;
    logic [1:0]       som_q, som_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             core_enable_q, core_enable_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             wdog_expired_s;
    logic             cfg_load_s;

    // A configuration pulse only takes effect while idle.
    assign cfg_load_s = (state_q == IDLE) & cfg_start;

`ifdef IBR128_SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              waiting_s;
    logic              err_q, err_d;

    // Cycles where the FSM is blocked on the core: RUN before cipherReady
    // rises, DRAIN before it falls.
    assign waiting_s = ((state_q == RUN)   & ~core_ready) |
                       ((state_q == DRAIN) &  core_ready);
    assign wdog_expired_s = waiting_s & (wdog_q == WDOG_LAST);

    // Watchdog counts every cycle spent in RUN or DRAIN, restarts elsewhere.
    always_comb begin
        wdog_d = wdog_q;
        if ((state_q == RUN) || (state_q == DRAIN)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end else begin
            wdog_d = '0;
        end
    end

    // Sticky error: set on expiry, cleared only by an accepted cfg_start.
    always_comb begin
        err_d = err_q;
        if (cfg_load_s) begin
            err_d = 1'b0;
        end else if (wdog_expired_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Watchdog and error flag registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wdog_expired_s = 1'b0;
    assign err            = 1'b0;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        text_d    = text_q;
        result_d  = result_q;
        chain_d   = chain_q;
        encrypt_d = encrypt_q;
        som_d     = som_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                // cfg_start has priority over an input block in the same cycle.
                if (cfg_start) begin
                    encrypt_d = cfg_encrypt;
                    som_d     = cfg_som;
                    chain_d   = cfg_iv;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (in_valid) begin
                    text_d  = in_data;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                // One setup cycle so text/IV are stable before Enable rises.
                state_d = RUN;
            end
            RUN: begin
                if (core_ready) begin
                    result_d = core_text_out;
                    state_d  = DRAIN;
                end else if (wdog_expired_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Wait for cipherReady to drop so the next block sees a fresh
                // rising edge rather than the stale level from this one.
                if (!core_ready) begin
                    state_d = OUT;
                end else if (wdog_expired_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            OUT: begin
                if (out_ready) begin
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
                    chain_d = chain_next(som_q, encrypt_q, result_q, text_q, chain_q);
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are glitch-free flops.
        core_enable_d = (state_d == RUN);
        out_valid_d   = (state_d == OUT);
        busy_d        = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= IDLE;
            text_q        <= '0;
            result_q      <= '0;
            chain_q       <= '0;
            encrypt_q     <= 1'b0;
            som_q         <= 2'b00;
            cnt_q         <= '0;
            core_enable_q <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            text_q        <= text_d;
            result_q      <= result_d;
            chain_q       <= chain_d;
            encrypt_q     <= encrypt_d;
            som_q         <= som_d;
            cnt_q         <= cnt_d;
            core_enable_q <= core_enable_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
        end
    end

    // in_ready must drop in the same cycle as cfg_start, so it is the only
    // output decoded from live inputs; it is also held low during reset.
    assign in_ready = ~busy_q & ~cfg_start & ~Rst;

    assign out_valid    = out_valid_q;
    assign out_data     = result_q;
    assign core_enable  = core_enable_q;
    assign core_encrypt = encrypt_q;
    assign core_som     = som_q;
    assign core_text    = text_q;
    // ECB and reserved modes present an all-zero IV to the core.
    assign core_iv      = som_is_cbc(som_q) ? chain_q : '0;
    assign blk_count    = cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ibr128_block_seq.sv
// -----------------------------------------------------------------------------
// tb_ibr128_block_seq
// Randomised bench for ibr128_block_seq. A simple invertible toy cipher stands
// in for the IBR128 core (fixed enable-to-ready latency per block). Expected
// results come from a session-level reference: ECB/CBC chaining computed
// directly from the block stream.
// -----------------------------------------------------------------------------
module tb_ibr128_block_seq;

    localparam int          CNT_W   = 4;
    localparam int          TMO     = 16;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;
    localparam logic [127:0] KEY    = 128'h3C1F_9A27_D40B_66E5_81C3_5F70_2B9E_A6D4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             cfg_start, cfg_encrypt;
    logic [1:0]       cfg_som;
    logic [127:0]     cfg_iv;
    logic             in_valid, in_ready;
    logic [127:0]     in_data;
    logic             out_valid, out_ready;
    logic [127:0]     out_data;
    logic             core_enable, core_encrypt, core_ready;
    logic [1:0]       core_som;
    logic [127:0]     core_text, core_iv, core_text_out;
    logic [CNT_W-1:0] blk_count;
    logic             busy, err;

    ibr128_block_seq #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .cfg_start(cfg_start), .cfg_encrypt(cfg_encrypt), .cfg_som(cfg_som), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_enable(core_enable), .core_encrypt(core_encrypt), .core_som(core_som),
        .core_text(core_text), .core_iv(core_iv), .core_text_out(core_text_out),
        .core_ready(core_ready), .blk_count(blk_count), .busy(busy), .err(err)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Toy block cipher: rotate left then xor key; decrypt is the inverse.
    function automatic logic [127:0] enc_blk(input logic [127:0] x);
        return {x[126:0], x[127]} ^ KEY;
    endfunction

    function automatic logic [127:0] dec_blk(input logic [127:0] x);
        logic [127:0] t;
        t = x ^ KEY;
        return {t[0], t[127:1]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- core model ----------------
    int core_lat   = 4;
    int core_cnt   = 0;
    bit core_stuck = 1'b0;

    always_comb begin
        if (core_encrypt) begin
            core_text_out = enc_blk(core_text ^ ((core_som == 2'b01) ? core_iv : 128'h0));
        end else begin
            core_text_out = dec_blk(core_text) ^ ((core_som == 2'b01) ? core_iv : 128'h0);
        end
    end

    always @(posedge Clk) begin
        if (!core_enable || core_stuck) begin
            core_cnt   <= 0;
            core_ready <= 1'b0;
        end else begin
            core_cnt <= core_cnt + 1;
            if (core_cnt + 1 >= core_lat) core_ready <= 1'b1;
        end
    end

    // ---------------- session reference ----------------
    bit           ref_enc   = 1'b0;
    logic [1:0]   ref_som   = 2'b00;
    logic [127:0] ref_chain = 128'h0;
    int           ref_count = 0;
    bit           ref_err   = 1'b0;

    task automatic ref_reset();
        ref_enc = 1'b0; ref_som = 2'b00; ref_chain = 128'h0; ref_count = 0; ref_err = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Configure a session; optionally offer a block at the same time to check
    // that cfg_start wins.
    task automatic do_cfg(input bit enc, input logic [1:0] som, input logic [127:0] iv, input bit with_valid);
        cfg_start = 1'b1; cfg_encrypt = enc; cfg_som = som; cfg_iv = iv;
        in_valid = with_valid; in_data = rand128();
        #1;
        check_val("cfg_in_ready", 128'(in_ready), 128'(0));
        step();
        cfg_start = 1'b0; in_valid = 1'b0;
        ref_enc = enc; ref_som = som; ref_chain = iv; ref_count = 0; ref_err = 1'b0;
        check_val("cfg_busy", 128'(busy), 128'(0));
        check_val("cfg_encrypt", 128'(core_encrypt), 128'(enc));
        check_val("cfg_som", 128'(core_som), 128'(som));
        check_val("cfg_count", 128'(blk_count), 128'(0));
        check_val("cfg_err", 128'(err), 128'(0));
    endtask

    // Offer a block and return just after the accepting edge.
    task automatic accept_block(input logic [127:0] data);
        int w;
        in_valid = 1'b1; in_data = data;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        check_val("in_ready_idle", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] data, input int lat, input int bp, input bit poke);
        int cyc, n_en, sat;
        bit prev_en;
        bit cbc;
        logic [127:0] exp_iv, exp_out;
        cbc     = (ref_som == 2'b01);
        exp_iv  = cbc ? ref_chain : 128'h0;
        exp_out = ref_enc ? enc_blk(data ^ exp_iv) : (dec_blk(data) ^ exp_iv);
        core_lat  = lat;
        out_ready = (bp == 0);
        accept_block(data);
        cyc = 0; n_en = 0; prev_en = 1'b0;
        while (!out_valid && cyc < 200) begin
            step();
            cyc++;
            if (core_enable && !prev_en) begin
                n_en++;
                check_val("core_iv", core_iv, exp_iv);
                check_val("core_text", core_text, data);
                check_val("core_encrypt", 128'(core_encrypt), 128'(ref_enc));
                check_val("core_som", 128'(core_som), 128'(ref_som));
            end
            prev_en = core_enable;
            check_val("busy_in_ready", 128'(in_ready), 128'(0));
            if (poke && cyc == 2) begin
                cfg_start = 1'b1; cfg_iv = rand128(); cfg_som = ~ref_som; cfg_encrypt = ~ref_enc;
            end else begin
                cfg_start = 1'b0;
            end
        end
        cfg_start = 1'b0;
        check_val("latency", 128'(cyc), 128'(lat + 4));
        check_val("out_data", out_data, exp_out);
        check_val("enable_pulses", 128'(n_en), 128'(1));
        for (int i = 0; i < bp; i++) begin
            step();
            check_val("bp_out_valid", 128'(out_valid), 128'(1));
            check_val("bp_out_data", out_data, exp_out);
            check_val("bp_in_ready", 128'(in_ready), 128'(0));
            check_val("bp_enable", 128'(core_enable), 128'(0));
        end
        out_ready = 1'b1;
        step();
        ref_count++;
        if (cbc) ref_chain = ref_enc ? exp_out : data;
        sat = (ref_count > CNT_SAT) ? CNT_SAT : ref_count;
        check_val("post_out_valid", 128'(out_valid), 128'(0));
        check_val("post_busy", 128'(busy), 128'(0));
        check_val("blk_count", 128'(blk_count), 128'(sat));
        check_val("err", 128'(err), 128'(ref_err));
    endtask

    initial begin
        Rst = 1'b1; cfg_start = 1'b0; cfg_encrypt = 1'b0; cfg_som = 2'b00; cfg_iv = 128'h0;
        in_valid = 1'b0; in_data = 128'h0; out_ready = 1'b0;
        repeat (3) step();
        check_val("rst_in_ready", 128'(in_ready), 128'(0));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_out_data", out_data, 128'h0);
        check_val("rst_enable", 128'(core_enable), 128'(0));
        check_val("rst_core_iv", core_iv, 128'h0);
        check_val("rst_core_text", core_text, 128'h0);
        check_val("rst_count", 128'(blk_count), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_err", 128'(err), 128'(0));
        Rst = 1'b0;
        #1;
        check_val("idle_in_ready", 128'(in_ready), 128'(1));
        ref_reset();

        // ECB encrypt, fixed vector, 10-cycle core.
        do_cfg(1'b1, 2'b00, rand128(), 1'b1);
        run_block(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 10, 0, 1'b0);

        // CBC encrypt, three blocks.
        do_cfg(1'b1, 2'b01, {16{8'hA5}}, 1'b0);
        for (int i = 0; i < 3; i++) run_block(rand128(), int'($urandom_range(1, 10)), 0, 1'b0);

        // CBC decrypt, two blocks.
        do_cfg(1'b0, 2'b01, rand128(), 1'b1);
        for (int i = 0; i < 2; i++) run_block(rand128(), int'($urandom_range(1, 10)), 0, 1'b0);

        // Long backpressure plus an ignored cfg_start while busy.
        run_block(rand128(), 4, 20, 1'b1);

        // Counter saturation within one session.
        do_cfg(1'($urandom_range(0, 1)), 2'b01, rand128(), 1'b0);
        for (int i = 0; i < 18; i++) begin
            run_block(rand128(), int'($urandom_range(1, 10)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end

        // Random sessions including reserved SOM codes.
        for (int s = 0; s < 4; s++) begin
            do_cfg(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand128(),
                   1'($urandom_range(0, 1)));
            for (int i = 0; i < 5; i++) begin
                run_block(rand128(), int'($urandom_range(1, 10)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
            end
        end

        // Reset in the middle of RUN.
        core_lat = 10;
        accept_block(rand128());
        repeat (5) step();
        check_val("mid_enable", 128'(core_enable), 128'(1));
        Rst = 1'b1;
        step();
        check_val("mid_rst_busy", 128'(busy), 128'(0));
        check_val("mid_rst_enable", 128'(core_enable), 128'(0));
        check_val("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check_val("mid_rst_count", 128'(blk_count), 128'(0));
        Rst = 1'b0;
        ref_reset();
        #1;
        check_val("mid_rst_in_ready", 128'(in_ready), 128'(1));
        do_cfg(1'b1, 2'b01, rand128(), 1'b0);
        run_block(rand128(), 6, 1, 1'b0);
        run_block(rand128(), 3, 0, 1'b0);

`ifdef IBR128_SEQ_TIMEOUT_EN
        begin
            int  cyc;
            int  sat;
            bit  seen_out;
            core_stuck = 1'b1;
            accept_block(rand128());
            cyc = 0; seen_out = 1'b0;
            while (busy && cyc < 100) begin
                step();
                cyc++;
                if (out_valid) seen_out = 1'b1;
            end
            ref_err = 1'b1;
            sat = (ref_count > CNT_SAT) ? CNT_SAT : ref_count;
            check_val("tmo_cycles", 128'(cyc), 128'(TMO + 1));
            check_val("tmo_err", 128'(err), 128'(1));
            check_val("tmo_no_out", 128'(seen_out), 128'(0));
            check_val("tmo_count", 128'(blk_count), 128'(sat));
            check_val("tmo_enable", 128'(core_enable), 128'(0));
            core_stuck = 1'b0;
            // Chain must be untouched: the next block's IV check covers it.
            run_block(rand128(), 5, 0, 1'b0);
            do_cfg(1'b0, 2'b01, rand128(), 1'b0);
        end
`else
        check_val("no_wdog_err", 128'(err), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibr128_block_seq.md
Name: ibr128_block_seq

Overview:
- Sequencer placed in front of the IBR128 cipher core.
- Accepts a stream of 128-bit input blocks over a valid/ready handshake, loads each block plus the current chaining value into the core, and pulses the core enable.
- Waits for cipherReady, then returns each result on an output valid/ready stream.
- Maintains the chaining register for chained modes so that software no longer reprograms IV per block.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for cipherReady before aborting the block (used only when the optional feature is compiled in).
- CNT_W, 16: width of the session block counter.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous reset, active-high
- cfg_start  in  1  one-cycle pulse: latch cfg_*, clear counter, load chain register from cfg_iv
- cfg_encrypt  in  1  1 = encrypt, 0 = decrypt
- cfg_som  in  2  mode of operation: 00 ECB, 01 CBC, 10/11 reserved (treated as ECB)
- cfg_iv  in  128  initial chaining value
- in_valid  in  1  input block valid
- in_ready  out  1  sequencer accepts input block
- in_data  in  128  plaintext or ciphertext block
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  128  result block
- core_enable  out  1  to core Enable
- core_encrypt  out  1  to core Encrypt
- core_som  out  2  to core SOM
- core_text  out  128  to core plainText
- core_iv  out  128  to core IV
- core_text_out  in  128  from core cipherText
- core_ready  in  1  from core cipherReady
- blk_count  out  CNT_W  blocks completed since cfg_start; saturates at all-ones
- busy  out  1  FSM not in IDLE
- err  out  1  sticky timeout flag, cleared by cfg_start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; chain register 0; cfg registers 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the text register and go to LOAD.
  - LOAD: drive core_text and core_iv (= chain register); core_enable=0. Go to RUN next cycle.
  - RUN: core_enable=1. Wait for core_ready=1. On that cycle, capture core_text_out into the result register and go to DRAIN.
  - DRAIN: core_enable=0. Wait until core_ready=0, enforcing a fresh rising edge for the next block. Go to OUT.
  - OUT: out_valid=1 with out_data = result register, held stable until out_ready. On acceptance: increment blk_count, update chain register, go to IDLE.
- Chain register update (cfg_som=01 only):
  - Encrypt: chain <= result block.
  - Decrypt: chain <= the input ciphertext block that was consumed.
  - ECB/reserved modes: chain is unchanged.
- Latency: input acceptance to out_valid = 3 + core latency + cycles for core_ready to deassert. Throughput is at most one block per (latency + 2) cycles; there is no overlap between blocks.
- in_ready is 0 in every state except IDLE. cfg_start is ignored unless the FSM is in IDLE (busy=0).
- If cfg_start and in_valid are both asserted in IDLE in the same cycle, cfg_start wins: the block is not accepted that cycle and in_ready is forced to 0.
- core_encrypt and core_som are driven from the latched cfg registers and held constant for the session.
- blk_count saturates at 2^CNT_W-1 and does not wrap.
- Rst asserted mid-block: next cycle returns to IDLE, core_enable=0, out_valid=0, and the in-flight result is discarded.

Optional Feature:
- Macro: IBR128_SEQ_TIMEOUT_EN.
- Defined: a watchdog counter runs in RUN and DRAIN. When it reaches TIMEOUT_CYCLES:
  - set err;
  - drop core_enable;
  - go to IDLE with no out_valid;
  - leave chain register and blk_count unchanged.
- Not defined: no watchdog. The sequencer waits indefinitely, err is tied to 0, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package ibr128_pkg holds:
  - typedef enum for the FSM states (IDLE, LOAD, RUN, DRAIN, OUT);
  - typedef enum for SOM (SOM_ECB=2'b00, SOM_CBC=2'b01);
  - typedef logic [127:0] blk128_t.
- Sub-module: none needed. If the watchdog grows, it may be split out as ibr128_seq_wdog.

Test Plan:
- ECB encrypt, core model with 10-cycle latency, in_data=128'h0011..EEFF, out_ready=1: out_valid rises 14 cycles after acceptance (latency + 3 states + 1 DRAIN cycle); blk_count=1; core_iv=0.
- CBC encrypt, 3 blocks, cfg_iv=128'hA5A5..A5: core_iv for block 2 equals block 1 out_data, and block 3 uses block 2 out_data; blk_count=3.
- CBC decrypt, 2 blocks C1, C2, cfg_iv=IV0: core_iv is IV0 for the first block and C1 for the second.
- Backpressure: out_ready=0 for 20 cycles in OUT: out_data stable, in_ready=0, no second core_enable; after out_ready=1, blk_count increments exactly once.
- Rst asserted during RUN at cycle 5: next cycle busy=0, core_enable=0, out_valid=0; a subsequent block completes normally.
- With IBR128_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_ready stuck at 0: err=1 after 16 RUN cycles, FSM returns to IDLE, blk_count unchanged; cfg_start clears err.
